// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer_irq block.
//   - timer_state_e : FSM state encoding (also driven out on the debug port)
//   - ADDR_*        : register select codes on Addr
//   - CTRL_*        : bit positions inside the CTRL register
//   - MODE_*        : CTRL.Mode codes (codes 2 and 3 behave as one-shot)
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_BITS    = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_irq.sv
// timer_irq: programmable down-counter with interrupt request.
//
// Ports
//   clk       : single clock, all state on rising edge
//   reset     : synchronous, active-low
//   Addr[1:0] : register select (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   WE        : write enable, sampled at the clock edge
//   Din[W-1:0]: write data
//   Dout      : combinational read data for Addr
//   IRQ       : irq_flag AND CTRL.IM
//   dbg_state : current FSM state, for observation only
//
// Bus semantics: a write is a single-cycle strobe. When WE=1 at a rising
// edge the addressed register takes Din on that edge; there is no
// back-pressure and no wait state. Reads are purely combinational.
module timer_irq
  import timer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   Addr,
  input  logic         WE,
  input  logic [W-1:0] Din,
  output logic [W-1:0] Dout,
  output logic         IRQ,
  output timer_state_e dbg_state
);

  localparam logic [W-1:0] ONE = W'(1);

  timer_state_e state_q, state_d;
  logic [CTRL_BITS-1:0] ctrl_q;
  logic [W-1:0] preset_q;
  logic [W-1:0] count_q, count_d;
  logic         irq_flag_q;

  logic enable;
  logic [1:0] mode;
  logic ctrl_wr, preset_wr;
  logic flag_set;   // counter expired this edge
  logic flag_clr;   // entering or in LOAD
  logic en_clr;     // one-shot completion drops Enable

  assign enable    = ctrl_q[CTRL_EN];
  assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
  assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
  assign preset_wr = WE && (Addr == ADDR_PRESET);

  // Next-state logic. LOAD copies PRESET; the counter then stops at 1
  // rather than 0, which makes PRESET=0 time out exactly like PRESET=1
  // and keeps COUNT from ever wrapping.
  // flag_clr also fires on the edge that enters LOAD so that in
  // auto-reload the flag is high for the single INT cycle only.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_LOAD;
          flag_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        count_d  = preset_q;
        flag_clr = 1'b1;
        state_d  = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (mode == MODE_RELOAD) begin
          state_d  = ST_LOAD;
          flag_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
          en_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;

      // A software CTRL write overrides the one-shot Enable clear.
      if (ctrl_wr) begin
        ctrl_q <= Din[CTRL_BITS-1:0];
      end else if (en_clr) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (preset_wr) begin
        preset_q <= Din;
      end

      // Expiry beats any clearing source on the same edge.
      if (flag_set) begin
        irq_flag_q <= 1'b1;
      end else if (ctrl_wr || preset_wr || flag_clr) begin
        irq_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = W'(ctrl_q);
      ADDR_PRESET: Dout = preset_q;
      ADDR_COUNT:  Dout = count_q;
      default:     Dout = '0;
    endcase
  end

  assign IRQ       = irq_flag_q & ctrl_q[CTRL_IM];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed scenarios with fixed expected timings, followed by
// randomized bus traffic checked against a cycle-level reference model.
module tb_timer_irq;
  import timer_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [1:0]   Addr;
  logic         WE;
  logic [W-1:0] Din;
  logic [W-1:0] Dout;
  logic         IRQ;
  timer_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  timer_irq #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Addr      (Addr),
    .WE        (WE),
    .Din       (Din),
    .Dout      (Dout),
    .IRQ       (IRQ),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase codes: 0 idle, 1 load, 2 counting, 3 expired.
  logic [3:0]   m_ctrl;
  logic [W-1:0] m_preset;
  logic [W-1:0] m_count;
  logic         m_flag;
  int           m_phase;

  task automatic model_step(input logic we, input logic [1:0] a,
                            input logic [W-1:0] d, input logic rst_n);
    logic         en, autoreload, expire, clear;
    logic [3:0]   nc;
    logic [W-1:0] ncount;
    int           nph;
    if (!rst_n) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;
      return;
    end
    en         = m_ctrl[0];
    autoreload = (m_ctrl[2:1] == 2'd1);
    expire = 1'b0; clear = 1'b0;
    nc = m_ctrl; ncount = m_count; nph = m_phase;
    if (m_phase == 0) begin
      if (en) begin nph = 1; clear = 1'b1; end
    end else if (m_phase == 1) begin
      ncount = m_preset; clear = 1'b1; nph = 2;
    end else if (m_phase == 2) begin
      if (!en) nph = 0;
      else if (m_count >= 2) ncount = m_count - 1;
      else begin ncount = 0; expire = 1'b1; nph = 3; end
    end else begin
      if (autoreload) begin nph = 1; clear = 1'b1; end
      else begin nph = 0; nc[0] = 1'b0; end
    end
    if (we && a == ADDR_CTRL)   nc = d[3:0];
    if (we && a == ADDR_PRESET) m_preset = d;
    if (we && (a == ADDR_CTRL || a == ADDR_PRESET)) clear = 1'b1;
    if (expire) m_flag = 1'b1;
    else if (clear) m_flag = 1'b0;
    m_ctrl = nc; m_count = ncount; m_phase = nph;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic we, input logic [1:0] a,
                      input logic [W-1:0] d, input logic rst_n);
    WE = we; Addr = a; Din = d; reset = rst_n;
    @(posedge clk);
    model_step(we, a, d, rst_n);
    #1;
    WE = 1'b0; reset = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    step(1'b1, a, d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ADDR_CTRL, '0, 1'b1);
  endtask

  task automatic rd(input logic [1:0] a, output logic [W-1:0] v);
    Addr = a;
    #1;
    v = Dout;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
    logic [W-1:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, W'(IRQ), W'(exp));
  endtask

  task automatic chk_state(input string tag, input timer_state_e exp);
    chk(tag, W'(dbg_state), W'(exp));
  endtask

  task automatic check_model(input string tag);
    chk_reg({tag, "_ctrl"},   ADDR_CTRL,   W'(m_ctrl));
    chk_reg({tag, "_preset"}, ADDR_PRESET, m_preset);
    chk_reg({tag, "_count"},  ADDR_COUNT,  m_count);
    chk_reg({tag, "_rsvd"},   ADDR_RSVD,   '0);
    chk_irq({tag, "_irq"}, m_flag & m_ctrl[3]);
    chk({tag, "_state"}, W'(dbg_state), W'(m_phase));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0;

    // Reset, including reset overriding a simultaneous write.
    step(1'b1, ADDR_CTRL, 32'hF, 1'b0);
    step(1'b1, ADDR_PRESET, 32'h1234, 1'b0);
    chk_reg("rst_ctrl", ADDR_CTRL, '0);
    chk_reg("rst_preset", ADDR_PRESET, '0);
    chk_reg("rst_count", ADDR_COUNT, '0);
    chk_irq("rst_irq", 1'b0);
    chk_state("rst_state", ST_IDLE);

    // One-shot, PRESET=5, CTRL=0x9.
    wr(ADDR_PRESET, 5);
    wr(ADDR_CTRL, 32'h9);                       // e0
    chk_reg("os_ctrl", ADDR_CTRL, 32'h9);
    chk_state("os_e0_state", ST_IDLE);
    idle(1); chk_state("os_e1_load", ST_LOAD);
    idle(1); chk_reg("os_e2_count", ADDR_COUNT, 5); chk_state("os_e2_state", ST_CNT);
    idle(4); chk_reg("os_e6_count", ADDR_COUNT, 1); chk_irq("os_e6_irq", 1'b0);
    idle(1); chk_irq("os_e7_irq", 1'b1); chk_reg("os_e7_count", ADDR_COUNT, 0);
    chk_state("os_e7_state", ST_INT);
    idle(1); chk_state("os_e8_state", ST_IDLE); chk_reg("os_e8_ctrl", ADDR_CTRL, 32'h8);
    chk_irq("os_e8_irq", 1'b1);
    idle(3); chk_irq("os_hold_irq", 1'b1);
    wr(ADDR_CTRL, 32'h8); chk_irq("os_clr_irq", 1'b0);

    // CTRL write on the same edge as the one-shot Enable clear.
    wr(ADDR_CTRL, 32'h9);                       // e0
    idle(7); chk_state("race_e7_state", ST_INT); chk_irq("race_e7_irq", 1'b1);
    wr(ADDR_CTRL, 32'h9);                       // e8
    chk_reg("race_ctrl", ADDR_CTRL, 32'h9); chk_irq("race_irq", 1'b0);
    chk_state("race_state", ST_IDLE);
    idle(1); chk_state("race_reload", ST_LOAD);
    wr(ADDR_CTRL, 0); idle(2); chk_state("race_stop", ST_IDLE);

    // Auto-reload, PRESET=3, CTRL=0xB: pulse every 5 cycles.
    wr(ADDR_PRESET, 3);
    wr(ADDR_CTRL, 32'hB);                       // e0
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      chk_irq($sformatf("ar_irq_e%0d", k), (k == 5) || (k == 10));
      if (k == 7 || k == 12) chk_reg($sformatf("ar_count_e%0d", k), ADDR_COUNT, 3);
    end
    wr(ADDR_CTRL, 0); idle(2); chk_state("ar_stop", ST_IDLE);

    // IM=0 masks IRQ; setting IM on the expiry edge exposes the flag.
    wr(ADDR_PRESET, 2);
    wr(ADDR_CTRL, 32'h1);                       // e0
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
    end
    wr(ADDR_CTRL, 32'h9);                       // e4: expiry wins over clear
    chk_irq("mask_late_irq", 1'b1);
    idle(1); chk_state("mask_idle", ST_IDLE); chk_irq("mask_hold", 1'b1);
    wr(ADDR_CTRL, 0); chk_irq("mask_clr", 1'b0);

    // Disable mid-count holds COUNT; COUNT and reserved writes ignored.
    wr(ADDR_PRESET, 9);
    wr(ADDR_CTRL, 32'h1);                       // e0
    idle(6); chk_reg("dis_e6_count", ADDR_COUNT, 5);
    wr(ADDR_CTRL, 0);                           // e7
    chk_reg("dis_e7_count", ADDR_COUNT, 4);
    idle(1); chk_state("dis_state", ST_IDLE); chk_reg("dis_hold", ADDR_COUNT, 4);
    wr(ADDR_COUNT, 32'h55); chk_reg("ro_count", ADDR_COUNT, 4);
    wr(ADDR_RSVD, 32'hAA);
    chk_reg("rsvd_read", ADDR_RSVD, 0);
    chk_reg("rsvd_ctrl", ADDR_CTRL, 0);
    chk_reg("rsvd_preset", ADDR_PRESET, 9);

    // PRESET write on the expiry edge.
    wr(ADDR_PRESET, 2);
    wr(ADDR_CTRL, 32'h9);                       // e0
    idle(3); chk_reg("pw_e3_count", ADDR_COUNT, 1);
    wr(ADDR_PRESET, 32'h77);                    // e4
    chk_irq("pw_irq", 1'b1); chk_reg("pw_preset", ADDR_PRESET, 32'h77);
    wr(ADDR_CTRL, 0); idle(1);

    // PRESET=0 behaves as 1.
    wr(ADDR_PRESET, 0);
    wr(ADDR_CTRL, 32'h9);                       // e0
    idle(2); chk_reg("p0_count", ADDR_COUNT, 0); chk_irq("p0_e2_irq", 1'b0);
    idle(1); chk_irq("p0_e3_irq", 1'b1);
    wr(ADDR_CTRL, 0); idle(1);

    // PRESET write while counting, then reset mid-count at COUNT=7.
    wr(ADDR_PRESET, 20);
    wr(ADDR_CTRL, 32'h9);                       // e0
    idle(2); chk_reg("mr_e2_count", ADDR_COUNT, 20);
    wr(ADDR_PRESET, 3);                         // e3
    chk_reg("mr_e3_count", ADDR_COUNT, 19);
    idle(12); chk_reg("mr_e15_count", ADDR_COUNT, 7);
    step(1'b1, ADDR_CTRL, 32'hF, 1'b0);         // e16
    chk_reg("mr_ctrl", ADDR_CTRL, 0);
    chk_reg("mr_preset", ADDR_PRESET, 0);
    chk_reg("mr_count", ADDR_COUNT, 0);
    chk_state("mr_state", ST_IDLE);
    begin
      int irq_seen;
      irq_seen = 0;
      for (int k = 0; k < 25; k++) begin
        idle(1);
        if (IRQ !== 1'b0) irq_seen++;
      end
      chk("mr_no_irq", W'(irq_seen), 0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic         we_r, rst_r;
      logic [1:0]   a_r;
      logic [W-1:0] d_r;
      rst_r = ($urandom_range(0, 60) != 0);
      we_r  = ($urandom_range(0, 4) == 0);
      a_r   = 2'($urandom_range(0, 3));
      if (a_r == ADDR_PRESET)    d_r = W'($urandom_range(0, 6));
      else if (a_r == ADDR_CTRL) d_r = W'($urandom_range(0, 15));
      else                       d_r = W'($urandom);
      step(we_r, a_r, d_r, rst_r);
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the data and count width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-low reset: when 0 at a clk edge, the block is reset.
REQ-004 The block SHALL have port Addr, input, 2 bits, register select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-005 The block SHALL have port WE, input, 1 bit, bus write enable, sampled at the clk edge.
REQ-006 The block SHALL have port Din, input, W bits, bus write data.
REQ-007 The block SHALL have port Dout, output, W bits, combinational read data for Addr.
REQ-008 The block SHALL have port IRQ, output, 1 bit, the interrupt request driven into one HWInt line of the exception coprocessor.

Function
REQ-009 The CTRL register SHALL use these bits: [0] Enable, [2:1] Mode (0 one-shot, 1 auto-reload, 2/3 treated as 0), [3] IM interrupt mask; bits [W-1:4] SHALL read 0.
REQ-010 Writes SHALL take effect at the sampling edge: CTRL gets Din[3:0], PRESET gets Din, and writes to COUNT or Addr 3 SHALL be ignored.
REQ-011 Dout SHALL return CTRL, PRESET, COUNT, or 0 for Addr 0, 1, 2, 3 respectively.
REQ-012 The FSM SHALL have states IDLE, LOAD, CNT and INT.
REQ-013 In IDLE, the FSM SHALL go to LOAD if Enable=1, and otherwise stay in IDLE.
REQ-014 In LOAD, the block SHALL set COUNT to PRESET, clear irq_flag, and go to CNT.
REQ-015 In CNT with Enable=0, the FSM SHALL go to IDLE and COUNT SHALL hold.
REQ-016 In CNT with COUNT>1, COUNT SHALL decrement by 1; otherwise COUNT SHALL become 0, irq_flag SHALL be set, and the FSM SHALL go to INT.
REQ-017 In INT with Mode 0, Enable SHALL clear to 0, the FSM SHALL go to IDLE, and irq_flag SHALL hold.
REQ-018 In INT with Mode 1, the FSM SHALL go to LOAD, so irq_flag is high for exactly one cycle.
REQ-019 IRQ SHALL equal irq_flag AND IM.
REQ-020 A write to CTRL or PRESET SHALL clear irq_flag, except on an edge that sets irq_flag, where the set SHALL win.
REQ-021 A CTRL write on the same edge as the INT Mode-0 Enable clear SHALL win.
REQ-022 A PRESET write while counting SHALL NOT alter COUNT until the next LOAD.
REQ-023 For PRESET=N>=1 and Enable written at edge e0, the block SHALL reach LOAD at e1, reach COUNT=N at e2, and assert IRQ after e(N+2).
REQ-024 PRESET=0 SHALL behave as PRESET=1.
REQ-025 In Mode 1, the reload period SHALL be N+2 cycles.
REQ-026 COUNT SHALL never wrap below 0.

Reset
REQ-027 When reset=0 at an edge, CTRL, PRESET and COUNT SHALL become 0, the state SHALL become IDLE, irq_flag SHALL become 0, and IRQ=0 and Dout SHALL follow Addr.
REQ-028 Reset SHALL override a simultaneous WE.
REQ-029 Reset in mid-count SHALL abort counting with no IRQ pulse.

Structure
REQ-030 Package timer_pkg SHALL hold the state encoding, the register index constants, the CTRL bit positions and the Mode codes.
REQ-031 The block SHALL be a single module with no sub-module.

Verification
REQ-032 Scenario: PRESET=5, CTRL=0x9 written at e0 -> COUNT=5 after e2, 1 after e6, IRQ=1 after e7, state IDLE and Enable=0 after e8, IRQ held until a CTRL write.
REQ-033 Scenario: PRESET=3, CTRL=0xB (auto-reload, IM) -> IRQ one-cycle pulses every 5 cycles, and COUNT reloads to 3.
REQ-034 Scenario: CTRL=0x1 (IM=0) with PRESET=2 -> IRQ stays 0 throughout, while irq_flag behaviour is unchanged (asserting IM later raises IRQ).
REQ-035 Scenario: CTRL=0x0 written while COUNT=4 -> IDLE after two edges with COUNT held at 4; a write to COUNT of 0x55 -> Dout still reads 4.
REQ-036 Scenario: a PRESET write on the same edge as COUNT 1->0 -> irq_flag=1 and PRESET updated.
REQ-037 Scenario: PRESET=0 -> IRQ after e3.
REQ-038 Scenario: reset=0 mid-count with COUNT=7 -> all registers 0, state IDLE, IRQ=0 on the next cycle.
